// File: rtl/fftdisplay_loader.sv
// fftdisplay_loader: round-robins two FFT bin streams onto a double-buffered display RAM write port.
// Define FFTDISPLAY_LOG_EN for log2-approximated pixel heights instead of linear truncation.
module fftdisplay_loader #(
    parameter int LOGFFTSIZE = 11,
    parameter int LOGDSPSIZE = 10,
    parameter int AUDIOWIDTH = 16,
    parameter int DISPLWIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    vsync,
    input  logic                    ch0_valid,
    input  logic [LOGFFTSIZE-1:0]   ch0_index,
    input  logic [AUDIOWIDTH-1:0]   ch0_mag,
    output logic                    ch0_ready,
    input  logic                    ch1_valid,
    input  logic [LOGFFTSIZE-1:0]   ch1_index,
    input  logic [AUDIOWIDTH-1:0]   ch1_mag,
    output logic                    ch1_ready,
    output logic                    wr_en,
    output logic [LOGDSPSIZE:0]     wr_addr,
    output logic [2*DISPLWIDTH-1:0] wr_data,
    output logic [1:0]              wr_be,
    output logic                    rd_bank,
    output logic [7:0]              swap_count
);
    typedef enum logic [1:0] {IDLE, CAPT, DONE} chan_state_t;

    localparam logic [LOGFFTSIZE-1:0] LAST_BIN = LOGFFTSIZE'((1 << LOGDSPSIZE) - 1);

    chan_state_t st0_q, st0_d, st1_q, st1_d;
    logic ptr_q, ptr_d;
    logic vsync_q;
    logic vs_pend_q, vs_pend_d;
    logic rd_bank_q, rd_bank_d;
    logic [7:0] swap_count_q, swap_count_d;
    logic s1_valid_q, s1_valid_d;
    logic [LOGDSPSIZE:0] s1_addr_q, s1_addr_d;
    logic [2*DISPLWIDTH-1:0] s1_data_q, s1_data_d;
    logic [1:0] s1_be_q, s1_be_d;
    logic wr_en_q, wr_en_d;
    logic [LOGDSPSIZE:0] wr_addr_q, wr_addr_d;
    logic [2*DISPLWIDTH-1:0] wr_data_q, wr_data_d;
    logic [1:0] wr_be_q, wr_be_d;

    logic grant0, grant1, xfer0, xfer1, swap, bin_wr;
    logic [LOGFFTSIZE-1:0] sel_index;
    logic [AUDIOWIDTH-1:0] sel_mag;
    logic [DISPLWIDTH-1:0] height;

    function automatic logic bin_written(input chan_state_t st, input logic [LOGFFTSIZE-1:0] idx);
        logic wr;
        wr = 1'b0;
        case (st)
            IDLE:    wr = (idx == '0);
            CAPT:    wr = (idx <= LAST_BIN);
            default: wr = 1'b0;
        endcase
        return wr;
    endfunction

    function automatic chan_state_t bin_next(input chan_state_t st, input logic [LOGFFTSIZE-1:0] idx);
        chan_state_t nxt;
        nxt = st;
        case (st)
            IDLE:    nxt = (idx == '0) ? CAPT : IDLE;
            CAPT:    nxt = (idx == LAST_BIN) ? DONE : CAPT;
            default: nxt = DONE;
        endcase
        return nxt;
    endfunction

    // When both channels are waiting, the one that did not win last time is granted.
    always_comb begin
        grant0 = ch0_valid;
        grant1 = ch1_valid;
        if (ch0_valid && ch1_valid) begin
            grant0 = ~ptr_q;
            grant1 = ptr_q;
        end
    end

    assign ch0_ready = grant0 & ~rst;
    assign ch1_ready = grant1 & ~rst;
    assign xfer0     = ch0_valid & ch0_ready;
    assign xfer1     = ch1_valid & ch1_ready;
    assign sel_index = xfer1 ? ch1_index : ch0_index;
    assign sel_mag   = xfer1 ? ch1_mag : ch0_mag;

`ifdef FFTDISPLAY_LOG_EN
    logic [3:0] lead;
    logic [3:0] frac;
    always_comb begin
        lead = 4'd0;
        frac = 4'd0;
        for (int i = 0; i < AUDIOWIDTH; i++) begin
            if (sel_mag[i]) lead = 4'(i);
        end
        for (int k = 0; k < 4; k++) begin
            if (lead > 4'(k)) frac[3-k] = sel_mag[lead - 4'(k + 1)];
        end
        height = {lead, frac};
    end
`else
    logic unused_mag_low;
    assign height         = sel_mag[AUDIOWIDTH-1 -: DISPLWIDTH];
    assign unused_mag_low = ^sel_mag[AUDIOWIDTH-DISPLWIDTH-1:0];
`endif

    // Banks may only swap once both frames are complete and nothing is still headed for the RAM.
    assign swap = (st0_q == DONE) && (st1_q == DONE) && vs_pend_q && !s1_valid_q && !wr_en_q;

    always_comb begin
        st0_d  = st0_q;
        st1_d  = st1_q;
        ptr_d  = ptr_q;
        bin_wr = 1'b0;
        if (xfer0) begin
            bin_wr = bin_written(st0_q, ch0_index);
            st0_d  = bin_next(st0_q, ch0_index);
            ptr_d  = 1'b1;
        end
        if (xfer1) begin
            bin_wr = bin_written(st1_q, ch1_index);
            st1_d  = bin_next(st1_q, ch1_index);
            ptr_d  = 1'b0;
        end
        if (swap) begin
            st0_d = IDLE;
            st1_d = IDLE;
        end

        vs_pend_d = vs_pend_q;
        if (swap || vsync) vs_pend_d = 1'b0;
        else if (vsync_q && !vsync) vs_pend_d = 1'b1;
        rd_bank_d    = rd_bank_q ^ swap;
        swap_count_d = swap_count_q + 8'(swap);

        s1_valid_d = bin_wr;
        s1_addr_d  = {~rd_bank_q, sel_index[LOGDSPSIZE-1:0]};
        s1_data_d  = {height, height};
        s1_be_d    = bin_wr ? (xfer1 ? 2'b01 : 2'b10) : 2'b00;

        wr_en_d   = s1_valid_q;
        wr_be_d   = s1_be_q;
        wr_addr_d = s1_valid_q ? s1_addr_q : wr_addr_q;
        wr_data_d = s1_valid_q ? s1_data_q : wr_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st0_q        <= IDLE;
            st1_q        <= IDLE;
            ptr_q        <= 1'b0;
            vsync_q      <= 1'b1;
            vs_pend_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            swap_count_q <= 8'd0;
            s1_valid_q   <= 1'b0;
            s1_addr_q    <= '0;
            s1_data_q    <= '0;
            s1_be_q      <= 2'b00;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_be_q      <= 2'b00;
        end else begin
            st0_q        <= st0_d;
            st1_q        <= st1_d;
            ptr_q        <= ptr_d;
            vsync_q      <= vsync;
            vs_pend_q    <= vs_pend_d;
            rd_bank_q    <= rd_bank_d;
            swap_count_q <= swap_count_d;
            s1_valid_q   <= s1_valid_d;
            s1_addr_q    <= s1_addr_d;
            s1_data_q    <= s1_data_d;
            s1_be_q      <= s1_be_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            wr_be_q      <= wr_be_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign wr_be      = wr_be_q;
    assign rd_bank    = rd_bank_q;
    assign swap_count = swap_count_q;
endmodule
